csr_file: RTL
=============

# csr_file

Machine-mode CSR unit for the single-cycle RV32 core. It replaces the minimal mcycle/ID block embedded in the register file. It implements the full Zicsr read-modify-write ops (write/set/clear) and 64-bit mcycle/minstret counters. It also holds the trap CSRs (mstatus, mtvec, mepc, mcause) needed for ecall/mret, and sits beside the GPR file, driven by the decoder and the PC/next-PC logic.

## Interface
Parameters:
- XLEN, 32, data width (only 32 supported; counters are 64-bit, split lo/hi)
- MVENDORID, 32'h79737978, value of mvendorid (0xF11)
- MARCHID, 32'h017eb18f, value of marchid (0xF12)
- MHARTID, 0, value of mhartid (0xF14)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- csr_addr  in  12  CSR address of current instruction
- csr_op  in  2  00 none, 01 write (csrrw), 10 set (csrrs), 11 clear (csrrc)
- csr_wdata  in  XLEN  rs1 value or zero-extended uimm
- csr_rdata  out  XLEN  old value of addressed CSR (combinational)
- csr_illegal  out  1  access to unimplemented CSR or write to read-only CSR
- instret  in  1  one instruction retires this cycle
- ecall  in  1  take environment-call trap this cycle
- mret  in  1  execute mret this cycle
- trap_pc  in  XLEN  PC of the ecall instruction
- trap_target  out  XLEN  {mtvec[31:2],2'b00}
- mret_target  out  XLEN  mepc

## Operation
- CSR map: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, mvendorid 0xF11, marchid 0xF12, mhartid 0xF14.
- Write value for write ops: write = wdata; set = old|wdata; clear = old&~wdata.
- Set/clear with csr_wdata==0 is a pure read: no state change, no illegal on read-only CSRs.
- Illegal cases:
  - Any op other than none to an unmapped address.
  - Write, or set/clear with nonzero mask, to 0xF1x.
  - When illegal: csr_illegal=1, csr_rdata=0, no state change.
- mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
- mepc: bits[1:0] forced to 0 on any write. mtvec: stored as written (direct mode only). mcause: fully writable.
- mcycle: increments by 1 every cycle; 64-bit carry from lo into hi; wraps from all-ones to 0.
- minstret: increments by 1 when instret=1.
- CSR write to a counter half:
  - The written half takes csr_wdata.
  - The other half holds.
  - No increment of that counter that cycle.
- ecall:
  - mepc<=trap_pc with bits[1:0] cleared; mcause<=11.
  - MPIE<=MIE; MIE<=0.
- mret:
  - MIE<=MPIE; MPIE<=1.
- Priority, highest first: rst > ecall > mret > CSR write.
  - Lower-priority trap-CSR updates are dropped that cycle.
  - Counters still increment under ecall/mret.

## Timing
- Reads are combinational from current state; csr_rdata for a read-modify-write is the pre-update value.
- All writes, trap updates and counter increments take effect at the next rising edge (latency 1).
- trap_target/mret_target are combinational from registered mtvec/mepc. An ecall in cycle N makes the new mepc visible in cycle N+1.
- Reset (any cycle, including mid-trap) loads, on the next edge:
  - mstatus=0x00001800, mtvec=0, mepc=0, mcause=0.
  - mcycle=0, minstret=0.
- While rst=1, writes and increments are suppressed. Outputs reflect the reset state from the cycle after the reset edge.
- Counters are not readable mid-carry: lo/hi update in the same edge.

## Test plan
- Counters after reset: rst 1 cycle, then 10 idle cycles -> read 0xB00 returns 10, 0xB80 returns 0; pulse instret 3 times -> 0xB02 returns 3.
- Counter carry: write mcycle=0xFFFFFFFF, then 1 idle cycle -> mcycle=0, mcycleh=1; 1 more cycle -> mcycle=1.
- Set/clear: write mtvec=0x80000100, set 0x3 -> rdata old 0x80000100, new 0x80000103, trap_target 0x80000100; clear 0x100 -> 0x80000003.
- Trap round-trip:
  - Write mstatus=0x8 (MIE=1) -> reads 0x1808.
  - ecall with trap_pc=0x80000044 -> mepc=0x80000044, mcause=11, mstatus=0x1880.
  - mret -> mstatus=0x1888, mret_target=0x80000044.
- Illegal access: write 0xF11 -> csr_illegal=1 and mvendorid unchanged; set 0xF11 with mask 0 -> 0x79737978 and illegal=0; read 0x7C0 -> illegal=1, rdata=0.
- Collisions:
  - ecall plus CSR write to mepc in the same cycle -> mepc=trap_pc.
  - ecall plus mret -> ecall effects only.
  - rst during ecall -> reset values.

Source files
------------

// File: rtl/csr_file.sv
// csr_file - machine-mode CSR unit for the single-cycle RV32 core.
//
// Implements Zicsr read-modify-write access (write/set/clear), the 64-bit
// mcycle/minstret counters and the trap CSRs used by ecall/mret.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   csr_addr     CSR address of the current instruction
//   csr_op       00 none, 01 write, 10 set, 11 clear
//   csr_wdata    rs1 value or zero-extended uimm
//   csr_rdata    pre-update value of the addressed CSR (0 when illegal)
//   csr_illegal  unmapped access or write to a read-only CSR
//   instret      one instruction retires this cycle
//   ecall        take an environment-call trap this cycle
//   mret         execute mret this cycle
//   trap_pc      PC of the ecall instruction
//   trap_target  {mtvec[31:2], 2'b00}
//   mret_target  mepc
module csr_file #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MVENDORID = 32'h79737978,
  parameter logic [XLEN-1:0] MARCHID   = 32'h017eb18f,
  parameter logic [XLEN-1:0] MHARTID   = 32'h00000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            instret,
  input  logic            ecall,
  input  logic            mret,
  input  logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] mret_target
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;

  logic            mapped;
  logic            read_only;
  logic            wr_req;
  logic            wr_en;
  logic            trap_wr_en;
  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] rd_val;
  logic [XLEN-1:0] wr_val;

  // MPP is hardwired to M-mode (2'b11); only MIE and MPIE hold state.
  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mpie_q;
    mstatus_rd[3]     = mie_q;
  end

  always_comb begin
    rd_val    = '0;
    mapped    = 1'b1;
    read_only = 1'b0;
    unique case (csr_addr)
      A_MSTATUS:   rd_val = mstatus_rd;
      A_MTVEC:     rd_val = mtvec_q;
      A_MEPC:      rd_val = mepc_q;
      A_MCAUSE:    rd_val = mcause_q;
      A_MCYCLE:    rd_val = mcycle_q[31:0];
      A_MINSTRET:  rd_val = minstret_q[31:0];
      A_MCYCLEH:   rd_val = mcycle_q[63:32];
      A_MINSTRETH: rd_val = minstret_q[63:32];
      A_MVENDORID: begin rd_val = MVENDORID; read_only = 1'b1; end
      A_MARCHID:   begin rd_val = MARCHID;   read_only = 1'b1; end
      A_MHARTID:   begin rd_val = MHARTID;   read_only = 1'b1; end
      default:     mapped = 1'b0;
    endcase
  end

  // Set/clear with a zero mask is a pure read and never counts as a write.
  always_comb begin
    wr_req      = (csr_op == OP_WRITE) || (csr_op[1] && (csr_wdata != '0));
    csr_illegal = ((csr_op != 2'b00) && !mapped) || (read_only && wr_req);
    csr_rdata   = csr_illegal ? '0 : rd_val;
    wr_en       = wr_req && mapped && !csr_illegal;
    trap_wr_en  = wr_en && !ecall && !mret;
    unique case (csr_op)
      OP_WRITE: wr_val = csr_wdata;
      OP_SET:   wr_val = rd_val | csr_wdata;
      OP_CLEAR: wr_val = rd_val & ~csr_wdata;
      default:  wr_val = rd_val;
    endcase
  end

  // A software write to a counter half replaces that cycle's increment;
  // counter writes are not blocked by a concurrent trap.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = instret ? (minstret_q + 64'd1) : minstret_q;
    if (wr_en) begin
      if (csr_addr == A_MCYCLE)    mcycle_d   = {mcycle_q[63:32], wr_val};
      if (csr_addr == A_MCYCLEH)   mcycle_d   = {wr_val, mcycle_q[31:0]};
      if (csr_addr == A_MINSTRET)  minstret_d = {minstret_q[63:32], wr_val};
      if (csr_addr == A_MINSTRETH) minstret_d = {wr_val, minstret_q[31:0]};
    end
  end

  // ecall beats mret beats a software write to the trap CSRs.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (ecall) begin
      mepc_d   = {trap_pc[XLEN-1:2], 2'b00};
      mcause_d = XLEN'(11);
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (trap_wr_en) begin
      unique case (csr_addr)
        A_MSTATUS: begin
          mie_d  = wr_val[3];
          mpie_d = wr_val[7];
        end
        A_MTVEC:  mtvec_d  = wr_val;
        A_MEPC:   mepc_d   = {wr_val[XLEN-1:2], 2'b00};
        A_MCAUSE: mcause_d = wr_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign trap_target = {mtvec_q[XLEN-1:2], 2'b00};
  assign mret_target = mepc_q;

endmodule
